// File: rtl/vend_pkg.sv
// Shared types and defaults for the product/coin dispenser.
// Used by vend_dispenser; also referenced by its testbench.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_ERROR    = 2'd3
    } state_t;

    typedef enum logic {
        PROD = 1'b0,
        COIN = 1'b1
    } disp_t;

    localparam int unsigned PULSE_W_DEF = 4;
    localparam int unsigned TIMEOUT_DEF = 16;
    localparam int unsigned DEPTH_DEF   = 3;

    // Increment and service in the same cycle cancel; a request at depth is dropped.
    function automatic logic [2:0] pend_next(input logic [2:0] cur, input logic inc,
                                             input logic dec, input logic [2:0] depth);
        pend_next = cur;
        if (inc && !dec && cur != depth)
            pend_next = cur + 3'd1;
        else if (dec && !inc)
            pend_next = cur - 3'd1;
    endfunction

endpackage

// File: rtl/disp_timer.sv
// Loadable 8-bit down-counter with a zero flag; shared by the pulse and
// acknowledge-wait phases of the dispenser.
module disp_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       zero
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= 8'd0;
        else if (load)
            cnt <= load_val;
        else if (cnt != 8'd0)
            cnt <= cnt - 8'd1;
    end

    assign zero = (cnt == 8'd0);

endmodule

// File: rtl/vend_dispenser.sv
// Solenoid sequencer for product/coin dispensing with drop-sensor acknowledge.
// Define DISP_STATS_EN to build the 8-bit dispense statistics counters.
//
// state    | meaning
// IDLE     | nothing in progress; picks product first, then coin
// PULSE    | selected solenoid driven for PULSE_W cycles
// WAIT_ACK | waiting up to TIMEOUT cycles for the selected drop sensor
// ERROR    | no acknowledge seen; held until clr_err
module vend_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned PULSE_W = PULSE_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vend_req,
    input  logic       chg_req,
    input  logic       prod_drop,
    input  logic       coin_drop,
    input  logic       clr_err,
    output logic       prod_sol,
    output logic       coin_sol,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       ovf,
    output logic [7:0] prod_cnt_o,
    output logic [7:0] coin_cnt_o
);

    state_t     state, state_nxt;
    disp_t      sel, sel_nxt;
    logic [2:0] p_pend, c_pend;
    logic       tmr_load, tmr_zero;
    logic [7:0] tmr_val;
    logic       ack, p_dec, c_dec, p_lost, c_lost;

    disp_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // Only the selected sensor counts, and only while waiting for it.
    assign ack    = (state == ST_WAIT_ACK) && ((sel == PROD) ? prod_drop : coin_drop);
    assign p_dec  = ack && (sel == PROD);
    assign c_dec  = ack && (sel == COIN);
    assign p_lost = vend_req && !p_dec && (p_pend == 3'(DEPTH));
    assign c_lost = chg_req  && !c_dec && (c_pend == 3'(DEPTH));

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        tmr_load  = 1'b0;
        tmr_val   = 8'(PULSE_W - 1);
        case (state)
            ST_IDLE: begin
                if (p_pend != 3'd0) begin
                    sel_nxt   = PROD;
                    state_nxt = ST_PULSE;
                    tmr_load  = 1'b1;
                end else if (c_pend != 3'd0) begin
                    sel_nxt   = COIN;
                    state_nxt = ST_PULSE;
                    tmr_load  = 1'b1;
                end
            end
            ST_PULSE: begin
                if (tmr_zero) begin
                    state_nxt = ST_WAIT_ACK;
                    tmr_load  = 1'b1;
                    tmr_val   = 8'(TIMEOUT - 1);
                end
            end
            ST_WAIT_ACK: begin
                // An acknowledge in the final cycle still wins over the timeout.
                if (ack)
                    state_nxt = ST_IDLE;
                else if (tmr_zero)
                    state_nxt = ST_ERROR;
            end
            ST_ERROR: begin
                if (clr_err)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_IDLE;
            sel    <= PROD;
            p_pend <= 3'd0;
            c_pend <= 3'd0;
            done   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            state  <= state_nxt;
            sel    <= sel_nxt;
            p_pend <= pend_next(p_pend, vend_req, p_dec, 3'(DEPTH));
            c_pend <= pend_next(c_pend, chg_req, c_dec, 3'(DEPTH));
            done   <= ack;
            if (p_lost || c_lost)
                ovf <= 1'b1;
            else if (clr_err)
                ovf <= 1'b0;
        end
    end

    assign prod_sol = (state == ST_PULSE) && (sel == PROD);
    assign coin_sol = (state == ST_PULSE) && (sel == COIN);
    assign busy     = (state != ST_IDLE);
    assign err      = (state == ST_ERROR);

`ifdef DISP_STATS_EN
    logic [7:0] prod_cnt_q, coin_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_cnt_q <= 8'd0;
            coin_cnt_q <= 8'd0;
        end else begin
            if (p_dec)
                prod_cnt_q <= prod_cnt_q + 8'd1;
            if (c_dec)
                coin_cnt_q <= coin_cnt_q + 8'd1;
        end
    end

    assign prod_cnt_o = prod_cnt_q;
    assign coin_cnt_o = coin_cnt_q;
`else
    assign prod_cnt_o = 8'd0;
    assign coin_cnt_o = 8'd0;
`endif

endmodule
